// File: rtl/mmio_bridge_nslot.sv
// MMIO bridge: decodes CPU accesses to NUM_DEV address windows and runs
// a registered req/ack handshake with timeout, plus a registered IRQ stage.
module mmio_bridge_nslot #(
  parameter int                    NUM_DEV    = 2,
  parameter int                    WIN_BITS   = 4,
  parameter logic [NUM_DEV*32-1:0] BASE_ADDRS = {32'h0000_7F10, 32'h0000_7F00},
  parameter int                    TIMEOUT    = 15,
  parameter logic [31:0]           DEFAULT_RD = 32'h0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  PrReq,
  input  logic [31:0]           PrAddr,
  input  logic [31:0]           PrWD,
  input  logic [3:0]            PrWE,
  output logic [31:0]           PrRD,
  output logic                  PrReady,
  output logic                  PrErr,
  output logic [31:0]           Dev_Addr,
  output logic [31:0]           Dev_WD,
  output logic [3:0]            Dev_BE,
  output logic                  Dev_We,
  output logic [NUM_DEV-1:0]    Dev_Sel,
  input  logic [NUM_DEV*32-1:0] Dev_RD,
  input  logic [NUM_DEV-1:0]    Dev_Ack,
  input  logic [NUM_DEV-1:0]    Dev_IRQ,
  output logic [NUM_DEV-1:0]    IRQ
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

  state_t               r_state;
  state_t               w_state_nx;
  logic [7:0]           r_cnt;
  logic [7:0]           w_cnt_nx;
  logic [NUM_DEV-1:0]   r_sel;
  logic [NUM_DEV-1:0]   w_sel_nx;
  logic [31:0]          r_addr;
  logic [31:0]          w_addr_nx;
  logic [31:0]          r_wd;
  logic [31:0]          w_wd_nx;
  logic [3:0]           r_be;
  logic [3:0]           w_be_nx;
  logic                 r_we;
  logic                 w_we_nx;
  logic [31:0]          r_rd;
  logic [31:0]          w_rd_nx;
  logic                 r_ready;
  logic                 w_ready_nx;
  logic                 r_err;
  logic                 w_err_nx;
  logic [NUM_DEV-1:0]   r_irq;

  logic [NUM_DEV-1:0]   w_hit_oh;
  logic                 w_hit;
  logic [31:0]          w_sel_rd;
  logic                 w_sel_ack;

  // Scan from the top so the lowest overlapping slot is written last.
  always_comb begin
    w_hit_oh = '0;
    for (int k = NUM_DEV - 1; k >= 0; k--) begin
      if (PrAddr[31:WIN_BITS] ==
          BASE_ADDRS[k*32+WIN_BITS +: 32-WIN_BITS]) begin
        w_hit_oh    = '0;
        w_hit_oh[k] = 1'b1;
      end
    end
  end

  assign w_hit = |w_hit_oh;

  always_comb begin
    w_sel_rd = '0;
    for (int k = 0; k < NUM_DEV; k++) begin
      if (r_sel[k]) begin
        w_sel_rd = w_sel_rd | Dev_RD[k*32 +: 32];
      end
    end
  end

  assign w_sel_ack = |(Dev_Ack & r_sel);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_sel_nx   = r_sel;
    w_addr_nx  = r_addr;
    w_wd_nx    = r_wd;
    w_be_nx    = r_be;
    w_we_nx    = r_we;
    w_rd_nx    = r_rd;
    w_ready_nx = 1'b0;
    w_err_nx   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (PrReq) begin
          if (w_hit) begin
            w_addr_nx  = PrAddr;
            w_wd_nx    = PrWD;
            w_be_nx    = PrWE;
            w_we_nx    = |PrWE;
            w_sel_nx   = w_hit_oh;
            w_cnt_nx   = '0;
            w_state_nx = S_ACCESS;
          end else begin
            w_rd_nx    = DEFAULT_RD;
            w_err_nx   = 1'b1;
            w_ready_nx = 1'b1;
            w_state_nx = S_RESP;
          end
        end
      end
      S_ACCESS: begin
        // A late ack on the timeout boundary still completes normally.
        if (w_sel_ack) begin
          w_rd_nx    = r_we ? 32'h0 : w_sel_rd;
          w_ready_nx = 1'b1;
          w_sel_nx   = '0;
          w_state_nx = S_RESP;
        end else if (r_cnt == LP_CNT_LAST) begin
          w_rd_nx    = DEFAULT_RD;
          w_err_nx   = 1'b1;
          w_ready_nx = 1'b1;
          w_sel_nx   = '0;
          w_state_nx = S_RESP;
        end else begin
          w_cnt_nx = r_cnt + 8'd1;
        end
      end
      S_RESP: begin
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_sel   <= '0;
      r_addr  <= '0;
      r_wd    <= '0;
      r_be    <= '0;
      r_we    <= 1'b0;
      r_rd    <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nx;
      r_sel   <= w_sel_nx;
      r_addr  <= w_addr_nx;
      r_wd    <= w_wd_nx;
      r_be    <= w_be_nx;
      r_we    <= w_we_nx;
      r_rd    <= w_rd_nx;
      r_ready <= w_ready_nx;
      r_err   <= w_err_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_irq <= '0;
    end else begin
      r_irq <= Dev_IRQ;
    end
  end

  assign PrRD     = r_rd;
  assign PrReady  = r_ready;
  assign PrErr    = r_err;
  assign Dev_Addr = r_addr;
  assign Dev_WD   = r_wd;
  assign Dev_BE   = r_be;
  assign Dev_We   = r_we;
  assign Dev_Sel  = r_sel;
  assign IRQ      = r_irq;

endmodule

// File: tb/tb_mmio_bridge_nslot.sv
// Scoreboard bench for mmio_bridge_nslot: directed accesses push expected
// responses; a negedge monitor pops and checks each PrReady pulse.
module tb_mmio_bridge_nslot;

  localparam int          NUM_DEV = 2;
  localparam logic [31:0] DEF_RD  = 32'hBADC_0DE5;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  PrReq = 1'b0;
  logic [31:0]           PrAddr = '0;
  logic [31:0]           PrWD = '0;
  logic [3:0]            PrWE = '0;
  logic [31:0]           PrRD;
  logic                  PrReady;
  logic                  PrErr;
  logic [31:0]           Dev_Addr;
  logic [31:0]           Dev_WD;
  logic [3:0]            Dev_BE;
  logic                  Dev_We;
  logic [NUM_DEV-1:0]    Dev_Sel;
  logic [NUM_DEV*32-1:0] Dev_RD = '0;
  logic [NUM_DEV-1:0]    Dev_Ack = '0;
  logic [NUM_DEV-1:0]    Dev_IRQ = '0;
  logic [NUM_DEV-1:0]    IRQ;

  mmio_bridge_nslot #(
    .NUM_DEV   (NUM_DEV),
    .WIN_BITS  (4),
    .BASE_ADDRS({32'h0000_7F10, 32'h0000_7F00}),
    .TIMEOUT   (15),
    .DEFAULT_RD(DEF_RD)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .PrReq   (PrReq),
    .PrAddr  (PrAddr),
    .PrWD    (PrWD),
    .PrWE    (PrWE),
    .PrRD    (PrRD),
    .PrReady (PrReady),
    .PrErr   (PrErr),
    .Dev_Addr(Dev_Addr),
    .Dev_WD  (Dev_WD),
    .Dev_BE  (Dev_BE),
    .Dev_We  (Dev_We),
    .Dev_Sel (Dev_Sel),
    .Dev_RD  (Dev_RD),
    .Dev_Ack (Dev_Ack),
    .Dev_IRQ (Dev_IRQ),
    .IRQ     (IRQ)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every PrReady pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (PrReady === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_ready: got PrReady=1 expected none (cycle %0d)",
                 cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("PrRD", PrRD, e.rd);
        chk("PrErr", {31'b0, PrErr}, {31'b0, e.err});
        chk("latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Called and returns at a negedge with the bridge in IDLE.
  task automatic xact(input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] we, input logic [31:0] rdv,
                      input int sel_slot, input int ack_at, input int ack_slot,
                      input logic [31:0] exp_rd, input logic exp_err,
                      input int exp_lat, input int exp_sel, input bit hold);
    int  selc;
    bit  done;
    logic [NUM_DEV-1:0] oh;
    oh = '0;
    oh[sel_slot] = 1'b1;
    PrReq  = 1'b1;
    PrAddr = addr;
    PrWD   = wd;
    PrWE   = we;
    Dev_RD = '0;
    Dev_RD[sel_slot*32 +: 32] = rdv;
    sb.push_back('{exp_rd, exp_err, cyc + exp_lat});
    selc = 0;
    done = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (Dev_Sel != '0) begin
        selc++;
        chk("Dev_Sel", 32'(Dev_Sel), 32'(oh));
        chk("Dev_Addr", Dev_Addr, addr);
        chk("Dev_WD", Dev_WD, wd);
        chk("Dev_BE", 32'(Dev_BE), 32'(we));
        chk("Dev_We", 32'(Dev_We), 32'(we != 4'h0));
      end
      Dev_Ack = '0;
      if (ack_at > 0 && selc >= ack_at) Dev_Ack[ack_slot] = 1'b1;
      if (PrReady) done = 1'b1;
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL ready_wait: got no PrReady expected one within 64 cycles");
    end
    chk("sel_cycles", 32'(selc), 32'(exp_sel));
    Dev_Ack = '0;
    if (!hold) PrReq = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_PrRD", PrRD, 32'h0);
    chk("rst_PrReady", {31'b0, PrReady}, 32'h0);
    chk("rst_PrErr", {31'b0, PrErr}, 32'h0);
    chk("rst_Dev_Sel", 32'(Dev_Sel), 32'h0);
    chk("rst_Dev_Addr", Dev_Addr, 32'h0);
    chk("rst_IRQ", 32'(IRQ), 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // addr, wd, we, rdv, sel_slot, ack_at, ack_slot, exp_rd, err, lat, sel, hold
    xact(32'h7F14, 32'h0, 4'h0, 32'hDEAD_BEEF, 1, 1, 1,
         32'hDEAD_BEEF, 1'b0, 2, 1, 1'b0);
    xact(32'h7F08, 32'h1234_5678, 4'hF, 32'h55AA_55AA, 0, 4, 0,
         32'h0, 1'b0, 5, 4, 1'b0);
    xact(32'h7F20, 32'h0, 4'h0, 32'h0, 0, 0, 0,
         DEF_RD, 1'b1, 1, 0, 1'b0);
    xact(32'h7F00, 32'h0, 4'h0, 32'h1111_2222, 0, 0, 0,
         DEF_RD, 1'b1, 16, 15, 1'b0);
    xact(32'h7F00, 32'h0, 4'h0, 32'h1111_2222, 0, 15, 0,
         32'h1111_2222, 1'b0, 16, 15, 1'b0);
    xact(32'h7F04, 32'h0, 4'h0, 32'h3333_4444, 0, 1, 1,
         DEF_RD, 1'b1, 16, 15, 1'b0);
    xact(32'h7F1F, 32'h0, 4'h0, 32'hCAFE_F00D, 1, 2, 1,
         32'hCAFE_F00D, 1'b0, 3, 2, 1'b0);
    xact(32'h7EFF, 32'h0, 4'h0, 32'h0, 0, 0, 0,
         DEF_RD, 1'b1, 1, 0, 1'b0);
    xact(32'h7F1C, 32'hA5A5_0000, 4'h3, 32'h9999_9999, 1, 1, 1,
         32'h0, 1'b0, 2, 1, 1'b0);

    xact(32'h7F04, 32'h0, 4'h0, 32'h0A0B_0C0D, 0, 1, 0,
         32'h0A0B_0C0D, 1'b0, 2, 1, 1'b1);
    xact(32'h7F10, 32'h0, 4'h0, 32'h7777_8888, 1, 1, 1,
         32'h7777_8888, 1'b0, 2, 1, 1'b0);

    fork
      xact(32'h7F00, 32'h0, 4'h0, 32'h0, 0, 0, 0,
           DEF_RD, 1'b1, 16, 15, 1'b0);
      begin
        repeat (3) @(negedge clk);
        Dev_IRQ = 2'b10;
        chk("irq_before", 32'(IRQ), 32'h0);
        @(negedge clk);
        chk("irq_pulse", 32'(IRQ), 32'h2);
        Dev_IRQ = 2'b00;
        @(negedge clk);
        chk("irq_after", 32'(IRQ), 32'h0);
      end
    join

    PrReq  = 1'b1;
    PrAddr = 32'h7F00;
    PrWE   = 4'h0;
    @(negedge clk);
    chk("pre_abort_sel", 32'(Dev_Sel), 32'h1);
    reset = 1'b0;
    PrReq = 1'b0;
    @(negedge clk);
    chk("abort_sel", 32'(Dev_Sel), 32'h0);
    chk("abort_ready", {31'b0, PrReady}, 32'h0);
    chk("abort_PrRD", PrRD, 32'h0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    xact(32'h7F14, 32'h0, 4'h0, 32'h0BAD_F00D, 1, 1, 1,
         32'h0BAD_F00D, 1'b0, 2, 1, 1'b0);

    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
